// File: rtl/cbd_poly_packer.sv
// cbd_poly_packer
//
// Takes signed 4-bit CBD coefficients over a valid/ready handshake, maps each
// one into [0, Q), packs coefficient pairs into one RAM word (even coefficient
// in the low half) and writes the words to consecutive addresses through a
// write-request/grant handshake.
//
// Optional feature macro: CBD_PACK_RANGE_CHECK_EN
//   defined   : any accepted coefficient outside [-3, 3] sets err_range (sticky
//               until the next accepted start); the coefficient is still written.
//   undefined : no range-check logic, err_range tied low.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, base_addr         begin a polynomial (IDLE only); first word address
//   busy, done               not-IDLE indicator; one-cycle completion pulse
//   err_odd                  polynomial ended on an odd coefficient count
//   err_overflow             POLY_LENGTH coefficients arrived without coeff_last
//   err_range                out-of-range coefficient seen (see macro above)
//   coeff_valid/ready/data/last   upstream coefficient stream
//   mem_we, mem_addr, mem_wdata   RAM write request, held until mem_grant
//   mem_grant                RAM accepts the write this cycle
module cbd_poly_packer #(
  parameter int POLY_LENGTH = 256,
  parameter int COEFF_WIDTH = 12,
  parameter int Q           = 3329,
  parameter int ADDR_WIDTH  = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     err_odd,
  output logic                     err_overflow,
  output logic                     err_range,
  input  logic                     coeff_valid,
  output logic                     coeff_ready,
  input  logic [3:0]               coeff_data,
  input  logic                     coeff_last,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [2*COEFF_WIDTH-1:0] mem_wdata,
  input  logic                     mem_grant
);

  localparam int CNT_W = $clog2(POLY_LENGTH + 1);
  localparam logic [COEFF_WIDTH:0] Q_EXT   = (COEFF_WIDTH+1)'(Q);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(POLY_LENGTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   accept;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_inc;
  logic [COEFF_WIDTH-1:0] lo_reg;
  logic [COEFF_WIDTH:0]   c_ext;
  logic [COEFF_WIDTH-1:0] r;
  logic                   pair_last;

  assign coeff_ready = (state == S_LO) || (state == S_HI);
  assign accept      = coeff_valid && coeff_ready;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign mem_we      = (state == S_WRITE);
  assign count_inc   = count + CNT_W'(1);

  // Negative inputs are lifted by Q in COEFF_WIDTH+1 bits, then truncated.
  always_comb begin
    c_ext = {{(COEFF_WIDTH-3){coeff_data[3]}}, coeff_data};
    r     = COEFF_WIDTH'(coeff_data[3] ? (Q_EXT + c_ext) : c_ext);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LO;
      S_LO:    if (accept) state_next = coeff_last ? S_WRITE : S_HI;
      S_HI:    if (accept) state_next = S_WRITE;
      S_WRITE: if (mem_grant)
                 state_next = (pair_last || count == CNT_MAX) ? S_DONE : S_LO;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr     <= '0;
      mem_wdata    <= '0;
      count        <= '0;
      lo_reg       <= '0;
      pair_last    <= 1'b0;
      err_odd      <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mem_addr     <= base_addr;
          count        <= '0;
          err_odd      <= 1'b0;
          err_overflow <= 1'b0;
        end
        S_LO: if (accept) begin
          lo_reg    <= r;
          count     <= count_inc;
          pair_last <= coeff_last;
          if (coeff_last) begin
            mem_wdata <= {{COEFF_WIDTH{1'b0}}, r};
            err_odd   <= 1'b1;
          end
        end
        S_HI: if (accept) begin
          mem_wdata <= {r, lo_reg};
          count     <= count_inc;
          pair_last <= coeff_last;
          if (!coeff_last && count_inc == CNT_MAX) err_overflow <= 1'b1;
        end
        S_WRITE: if (mem_grant) mem_addr <= mem_addr + ADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end

`ifdef CBD_PACK_RANGE_CHECK_EN
  logic signed [3:0] c_s;
  assign c_s = coeff_data;

  always_ff @(posedge clk) begin
    if (rst)                             err_range <= 1'b0;
    else if (state == S_IDLE && start)   err_range <= 1'b0;
    else if (accept && (c_s < -4'sd3 || c_s > 4'sd3))
                                         err_range <= 1'b1;
  end
`else
  assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_cbd_poly_packer.sv
// Self-checking bench for cbd_poly_packer: directed scenarios plus randomized
// polynomials, compared against a pair-packing reference model.
module tb_cbd_poly_packer;

  localparam int QM = 3329;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  base_addr;
  logic        busy, done, err_odd, err_overflow, err_range;
  logic        coeff_valid, coeff_ready, coeff_last;
  logic [3:0]  coeff_data;
  logic        mem_we, mem_grant;
  logic [6:0]  mem_addr;
  logic [23:0] mem_wdata;

  logic grant_fix, grant_rand_en, grant_rnd;
  assign mem_grant = grant_rand_en ? grant_rnd : grant_fix;

  cbd_poly_packer #(
    .POLY_LENGTH(256),
    .COEFF_WIDTH(12),
    .Q(3329),
    .ADDR_WIDTH(7)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .err_odd(err_odd), .err_overflow(err_overflow),
    .err_range(err_range), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .coeff_data(coeff_data), .coeff_last(coeff_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_grant(mem_grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  logic [6:0]  wr_addr[$];
  logic [23:0] wr_data[$];
  int stim[$];
  int acc_base, done_base, wr_base, cyc_start, cyc_done;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    grant_rnd <= 1'($urandom_range(0, 1));
  end

  // Observes handshakes at the negedge; inputs are stable until the next posedge.
  always @(negedge clk) begin
    if (!rst && coeff_valid && coeff_ready) acc_cnt <= acc_cnt + 1;
    if (!rst && mem_we && mem_grant) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int map_c(input int c);
    return (c < 0) ? QM + c : c;
  endfunction

  function automatic logic [3:0] nib(input int c);
    return c[3:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ready"}, coeff_ready, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_err_odd"}, err_odd, 0);
    check({tag, "_err_ovf"}, err_overflow, 0);
    check({tag, "_err_rng"}, err_range, 0);
  endtask

  task automatic do_start(input logic [6:0] b);
    done_base = done_cnt;
    acc_base  = acc_cnt;
    wr_base   = wr_data.size();
    base_addr = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    cyc_start = cyc;
  endtask

  task automatic feed(input int first, input int cnt, input bit with_last, input int gap_pct);
    int t;
    for (int i = first; i < first + cnt; i++) begin
      if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        coeff_valid = 1'b0;
        @(posedge clk); #1;
      end
      coeff_valid = 1'b1;
      coeff_data  = nib(stim[i]);
      coeff_last  = with_last && (i == first + cnt - 1);
      t = 0;
      @(negedge clk);
      while (!coeff_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!coeff_ready) begin
        check("accept_timeout", coeff_ready, 1);
        coeff_valid = 1'b0;
        coeff_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    coeff_valid = 1'b0;
    coeff_last  = 1'b0;
  endtask

  task automatic wait_done(output int at);
    int t = 0;
    @(negedge clk);
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done, 1);
    at = cyc;
    @(posedge clk); #1;
  endtask

  // Reference: word i = {map(c[2i+1]) or 0, map(c[2i])} at (base + i) mod 128.
  task automatic check_writes(input string tag, input int base, input int n);
    int nw, got, bad, lo, hi, exp_w, exp_a;
    nw  = (n + 1) / 2;
    got = wr_data.size() - wr_base;
    check({tag, "_wr_count"}, got, nw);
    bad = 0;
    for (int i = 0; i < nw && i < got; i++) begin
      lo    = map_c(stim[2*i]);
      hi    = (2*i + 1 < n) ? map_c(stim[2*i+1]) : 0;
      exp_w = hi * 4096 + lo;
      exp_a = (base + i) % 128;
      if (wr_data[wr_base+i] !== 24'(exp_w) || wr_addr[wr_base+i] !== 7'(exp_a)) bad++;
    end
    check({tag, "_wr_words_bad"}, bad, 0);
  endtask

  initial begin
    int n, exp_rng, bad;
    logic [6:0]  a0;
    logic [23:0] d0, w;

    rst = 1'b1; start = 1'b0; base_addr = '0;
    coeff_valid = 1'b0; coeff_data = '0; coeff_last = 1'b0;
    grant_fix = 1'b1; grant_rand_en = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_reset("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // Full polynomial, alternating +1/-1, back-to-back
    stim.delete();
    for (int i = 0; i < 256; i++) stim.push_back((i % 2 == 0) ? 1 : -1);
    do_start(7'h10);
    check("t1_busy", busy, 1);
    check("t1_ready", coeff_ready, 1);
    feed(0, 256, 1, 0);
    wait_done(cyc_done);
    check("t1_busy_low", busy, 0);
    check("t1_latency", cyc_done - cyc_start, 384);
    check_writes("t1", 'h10, 256);
    check("t1_word0", wr_data[wr_base], 24'({12'd3328, 12'd1}));
    check("t1_err_odd", err_odd, 0);
    check("t1_err_ovf", err_overflow, 0);
    check("t1_err_rng", err_range, 0);
    repeat (3) @(posedge clk); #1;
    check("t1_done_pulses", done_cnt - done_base, 1);

    // Odd count
    stim.delete();
    stim.push_back(2); stim.push_back(-3); stim.push_back(1);
    do_start(7'h20);
    feed(0, 3, 1, 0);
    wait_done(cyc_done);
    check_writes("t2", 'h20, 3);
    check("t2_word1", wr_data[wr_base+1], 24'(1));
    check("t2_err_odd", err_odd, 1);
    check("t2_err_ovf", err_overflow, 0);

    // Grant backpressure, plus a start that must be ignored mid-poly
    stim.delete();
    stim.push_back(3); stim.push_back(-2); stim.push_back(1); stim.push_back(0);
    grant_fix = 1'b0;
    do_start(7'h30);
    feed(0, 2, 0, 0);
    check("t3_we", mem_we, 1);
    check("t3_addr", mem_addr, 'h30);
    check("t3_wdata", mem_wdata, 24'({12'd3327, 12'd3}));
    a0 = mem_addr; d0 = mem_wdata;
    coeff_valid = 1'b1; coeff_data = nib(stim[2]);
    start = 1'b1; base_addr = 7'h70;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_we !== 1'b1 || mem_addr !== a0 || mem_wdata !== d0 || coeff_ready !== 1'b0) bad++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("t3_hold_bad", bad, 0);
    check("t3_acc_stall", acc_cnt - acc_base, 2);
    grant_fix = 1'b1;
    feed(2, 2, 1, 0);
    wait_done(cyc_done);
    check_writes("t3", 'h30, 4);
    check("t3_acc_total", acc_cnt - acc_base, 4);

    // Randomized polynomials with random valid gaps and random grant
    grant_rand_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = int'($urandom_range(1, 60));
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(int'($urandom_range(0, 6)) - 3);
      w = 24'($urandom_range(0, 127));
      do_start(w[6:0]);
      feed(0, n, 1, 30);
      wait_done(cyc_done);
      check_writes("t4", int'(w[6:0]), n);
      check("t4_err_odd", err_odd, n % 2);
      check("t4_err_ovf", err_overflow, 0);
    end
    grant_rand_en = 1'b0;
    grant_fix = 1'b1;

    // Overflow: 300 coefficients offered, no last
    stim.delete();
    for (int i = 0; i < 300; i++) stim.push_back(int'($urandom_range(0, 6)) - 3);
    do_start(7'h05);
    feed(0, 256, 0, 0);
    coeff_valid = 1'b1; coeff_data = nib(stim[256]);
    wait_done(cyc_done);
    check_writes("t5", 'h05, 256);
    check("t5_err_ovf", err_overflow, 1);
    check("t5_err_odd", err_odd, 0);
    repeat (44) @(posedge clk); #1;
    check("t5_acc", acc_cnt - acc_base, 256);
    check("t5_ready", coeff_ready, 0);
    coeff_valid = 1'b0;

    // Reset mid-polynomial
    stim.delete();
    for (int i = 0; i < 60; i++) stim.push_back(int'($urandom_range(0, 6)) - 3);
    do_start(7'h40);
    feed(0, 40, 0, 0);
    check("t6_pre_we", mem_we, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("t6");
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("t6_no_done", done_cnt - done_base, 0);
    check("t6_writes", wr_data.size() - wr_base, 19);
    stim.delete();
    for (int i = 0; i < 5; i++) stim.push_back(int'($urandom_range(0, 6)) - 3);
    do_start(7'h7E);
    feed(0, 5, 1, 0);
    wait_done(cyc_done);
    check_writes("t6b", 'h7E, 5);
    check("t6b_err_odd", err_odd, 1);

    // Out-of-range coefficient
`ifdef CBD_PACK_RANGE_CHECK_EN
    exp_rng = 1;
`else
    exp_rng = 0;
`endif
    stim.delete();
    stim.push_back(-5);
    do_start(7'h00);
    feed(0, 1, 1, 0);
    wait_done(cyc_done);
    w = wr_data[wr_base];
    check("t7_lo", w[11:0], 3324);
    check("t7_err_rng", err_range, exp_rng);
    stim.delete();
    stim.push_back(1); stim.push_back(2);
    do_start(7'h01);
    check("t7_rng_cleared", err_range, 0);
    feed(0, 2, 1, 0);
    wait_done(cyc_done);
    check_writes("t7b", 'h01, 2);
    check("t7b_err_odd", err_odd, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
